// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and default width for the multi-cycle ALU.
// Pure declarations: no latency, no backpressure.
package alu_pkg;
   localparam int ALU_DEFAULT_WIDTH = 32;

   localparam int ALU_OPRN_ADD = 1;
   localparam int ALU_OPRN_SUB = 2;
   localparam int ALU_OPRN_MUL = 3;
   localparam int ALU_OPRN_SRL = 4;
   localparam int ALU_OPRN_SLL = 5;
   localparam int ALU_OPRN_AND = 6;
   localparam int ALU_OPRN_OR  = 7;
   localparam int ALU_OPRN_NOR = 8;
   localparam int ALU_OPRN_SLT = 9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MUL,
      ST_FIN
   } alu_state_e;
endpackage

// File: rtl/seq_mult_unit.sv
// Iterative signed shift-add multiplier: magnitudes multiplied over WIDTH steps, sign applied at the output.
// Latency WIDTH edges from start to the edge that consumes done; no backpressure, start restarts it.
module seq_mult_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             done
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               run_q, run_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod;

   // -2^(W-1) negates to itself, which is exactly its unsigned magnitude
   assign mag_a = a[WIDTH-1] ? -a : a;
   assign mag_b = b[WIDTH-1] ? -b : b;

   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      neg_d    = neg_q;
      if (start) begin
         // the first partial product is folded into the load step
         acc_d    = mag_b[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
         mcand_d  = {{(WIDTH-1){1'b0}}, mag_a, 1'b0};
         mplier_d = mag_b >> 1;
         cnt_d    = CW'(1);
         neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
         run_d    = 1'b1;
      end else if (run_q) begin
         if (cnt_q == CW'(WIDTH)) begin
            run_d = 1'b0;
         end else begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         neg_q    <= neg_d;
      end
   end

   assign prod = neg_q ? -acc_q : acc_q;
   assign hi   = prod[2*WIDTH-1:WIDTH];
   assign lo   = prod[WIDTH-1:0];
   assign done = run_q && (cnt_q == CW'(WIDTH));
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops finish 1 edge after acceptance, signed mul after WIDTH edges.
// START is taken only in IDLE or in the DONE cycle; START while BUSY is dropped.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH      = ALU_DEFAULT_WIDTH,
   parameter int OPRN_WIDTH = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [WIDTH-1:0]      OP1,
   input  logic [WIDTH-1:0]      OP2,
   input  logic [OPRN_WIDTH-1:0] OPRN,
   output logic [WIDTH-1:0]      OUT,
   output logic [WIDTH-1:0]      OUT_HI,
   output logic                  ZERO,
   output logic                  BUSY,
   output logic                  DONE
);
   alu_state_e            state_q, state_d;
   logic [WIDTH-1:0]      op1_q, op1_d;
   logic [WIDTH-1:0]      op2_q, op2_d;
   logic [OPRN_WIDTH-1:0] oprn_q, oprn_d;
   logic [WIDTH-1:0]      out_q, out_d;
   logic [WIDTH-1:0]      out_hi_q, out_hi_d;
   logic [WIDTH-1:0]      exec_res;
   logic [WIDTH-1:0]      mul_hi, mul_lo;
   logic                  mul_done;
   logic                  accept;
   logic                  mul_start;

   assign accept    = START && ((state_q == ST_IDLE) || (state_q == ST_FIN));
   assign mul_start = accept && (int'(OPRN) == ALU_OPRN_MUL);

   seq_mult_unit #(.WIDTH(WIDTH)) u_mult (
      .clk   (CLK),
      .rst   (RST),
      .start (mul_start),
      .a     (OP1),
      .b     (OP2),
      .hi    (mul_hi),
      .lo    (mul_lo),
      .done  (mul_done)
   );

   // SV shifts by an amount >= WIDTH already yield zero, matching the required behaviour
   always_comb begin
      exec_res = '0;
      case (int'(oprn_q))
         ALU_OPRN_ADD: exec_res = op1_q + op2_q;
         ALU_OPRN_SUB: exec_res = op1_q + ~op2_q + 1'b1;
         ALU_OPRN_SRL: exec_res = op1_q >> op2_q;
         ALU_OPRN_SLL: exec_res = op1_q << op2_q;
         ALU_OPRN_AND: exec_res = op1_q & op2_q;
         ALU_OPRN_OR:  exec_res = op1_q | op2_q;
         ALU_OPRN_NOR: exec_res = ~(op1_q | op2_q);
         ALU_OPRN_SLT: exec_res = {{(WIDTH-1){1'b0}}, ($signed(op1_q) < $signed(op2_q))};
         default:      exec_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      oprn_d   = oprn_q;
      out_d    = out_q;
      out_hi_d = out_hi_q;
      case (state_q)
         ST_IDLE, ST_FIN: begin
            if (START) begin
               op1_d   = OP1;
               op2_d   = OP2;
               oprn_d  = OPRN;
               state_d = (int'(OPRN) == ALU_OPRN_MUL) ? ST_MUL : ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            out_d    = exec_res;
            out_hi_d = '0;
            state_d  = ST_FIN;
         end
         ST_MUL: begin
            if (mul_done) begin
               out_d    = mul_lo;
               out_hi_d = mul_hi;
               state_d  = ST_FIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         op1_q    <= '0;
         op2_q    <= '0;
         oprn_q   <= '0;
         out_q    <= '0;
         out_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         oprn_q   <= oprn_d;
         out_q    <= out_d;
         out_hi_q <= out_hi_d;
      end
   end

   assign OUT    = out_q;
   assign OUT_HI = out_hi_q;
   assign ZERO   = (out_q == '0);
   assign BUSY   = (state_q == ST_EXEC) || (state_q == ST_MUL);
   assign DONE   = (state_q == ST_FIN);
endmodule
